// File: rtl/gmii_rx_speed_ctrl_if.sv
// Control/status bundle between the speed sequencer and the GMII/MII receiver.
// The master modport is the sequencer side; the slave modport is the config/receiver side.
interface gmii_rx_speed_ctrl_if;
  logic [1:0] cfg_speed;
  logic       gmii_rx_dv;
  logic       rx_clk_enable;
  logic       rx_mii_select;
  logic       rx_rst;
  logic [1:0] speed;
  logic       switch_busy;

  modport master (
    input  cfg_speed, gmii_rx_dv,
    output rx_clk_enable, rx_mii_select, rx_rst, speed, switch_busy
  );

  modport slave (
    output cfg_speed, gmii_rx_dv,
    input  rx_clk_enable, rx_mii_select, rx_rst, speed, switch_busy
  );
endinterface

// File: rtl/gmii_rx_speed_ctrl.sv
// Receiver clock-enable / MII-select sequencer; a speed change waits for an idle gap, then holds rx_rst to settle.
// All outputs registered; there is no backpressure, and requests are simply held pending until the line is quiet.
module gmii_rx_speed_ctrl #(
  parameter int CLK_DIV_100   = 5,
  parameter int CLK_DIV_10    = 50,
  parameter int IDLE_CYCLES   = 12,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gmii_rx_speed_ctrl_if.master ctrl_bus
);

  localparam int DIV_MAX = (CLK_DIV_10 > CLK_DIV_100) ? CLK_DIV_10 : CLK_DIV_100;
  localparam int DIV_W   = $clog2(DIV_MAX) + 1;
  localparam int IDLE_W  = $clog2(IDLE_CYCLES) + 1;
  localparam int SETL_W  = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [DIV_W-1:0]  DIV_ZERO     = '0;
  localparam logic [DIV_W-1:0]  DIV_ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_LAST_100 = DIV_W'(CLK_DIV_100 - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST_10  = DIV_W'(CLK_DIV_10 - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE     = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_DONE    = IDLE_W'(IDLE_CYCLES);
  localparam logic [SETL_W-1:0] SETL_ONE     = SETL_W'(1);
  localparam logic [SETL_W-1:0] SETL_LAST    = SETL_W'(SETTLE_CYCLES - 1);

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam logic [1:0] SPD_RSV  = 2'b11;

  typedef enum logic [1:0] {RUN, WAIT_IDLE, SWITCH, SETTLE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cur_speed, cur_speed_nxt;
  logic [1:0]        target, target_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [SETL_W-1:0] settle_cnt, settle_cnt_nxt;
  logic              clk_en, clk_en_nxt;
  logic              mii_sel, mii_sel_nxt;
  logic              rx_reset, rx_reset_nxt;
  logic              busy, busy_nxt;

  logic [DIV_W-1:0]  div_last;
  logic [DIV_W-1:0]  div_step;
  logic [IDLE_W-1:0] idle_step;
  logic              cfg_diff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SETTLE;
      cur_speed  <= SPD_1000;
      target     <= SPD_1000;
      div_cnt    <= '0;
      idle_cnt   <= '0;
      settle_cnt <= '0;
      clk_en     <= 1'b0;
      mii_sel    <= 1'b0;
      rx_reset   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_speed  <= cur_speed_nxt;
      target     <= target_nxt;
      div_cnt    <= div_cnt_nxt;
      idle_cnt   <= idle_cnt_nxt;
      settle_cnt <= settle_cnt_nxt;
      clk_en     <= clk_en_nxt;
      mii_sel    <= mii_sel_nxt;
      rx_reset   <= rx_reset_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cur_speed_nxt  = cur_speed;
    target_nxt     = target;
    div_cnt_nxt    = div_cnt;
    idle_cnt_nxt   = idle_cnt;
    settle_cnt_nxt = settle_cnt;
    clk_en_nxt     = clk_en;
    mii_sel_nxt    = mii_sel;
    rx_reset_nxt   = rx_reset;
    busy_nxt       = busy;

    case (cur_speed)
      SPD_1000: div_last = DIV_ZERO;
      SPD_100:  div_last = DIV_LAST_100;
      default:  div_last = DIV_LAST_10;
    endcase
    div_step  = (div_cnt >= div_last) ? DIV_ZERO : div_cnt + DIV_ONE;
    idle_step = (idle_cnt >= IDLE_DONE) ? IDLE_DONE : idle_cnt + IDLE_ONE;
    cfg_diff  = (ctrl_bus.cfg_speed != SPD_RSV) && (ctrl_bus.cfg_speed != cur_speed);

    case (state)
      RUN: begin
        div_cnt_nxt = div_step;
        clk_en_nxt  = (div_step == DIV_ZERO);
        if (cfg_diff) begin
          state_nxt    = WAIT_IDLE;
          target_nxt   = ctrl_bus.cfg_speed;
          idle_cnt_nxt = '0;
          busy_nxt     = 1'b1;
        end
      end
      WAIT_IDLE: begin
        // Old-speed enables keep flowing so any frame in progress completes intact.
        div_cnt_nxt = div_step;
        clk_en_nxt  = (div_step == DIV_ZERO);
        if (!cfg_diff) begin
          state_nxt = RUN;
          busy_nxt  = 1'b0;
        end else begin
          target_nxt = ctrl_bus.cfg_speed;
          if (ctrl_bus.gmii_rx_dv) begin
            idle_cnt_nxt = '0;
          end else begin
            idle_cnt_nxt = idle_step;
            if (idle_step == IDLE_DONE) state_nxt = SWITCH;
          end
        end
      end
      SWITCH: begin
        cur_speed_nxt  = target;
        mii_sel_nxt    = (target != SPD_1000);
        div_cnt_nxt    = DIV_ZERO;
        clk_en_nxt     = 1'b0;
        rx_reset_nxt   = 1'b1;
        settle_cnt_nxt = '0;
        state_nxt      = SETTLE;
      end
      SETTLE: begin
        clk_en_nxt   = 1'b0;
        rx_reset_nxt = 1'b1;
        if (settle_cnt >= SETL_LAST) begin
          state_nxt    = RUN;
          div_cnt_nxt  = DIV_ZERO;
          clk_en_nxt   = 1'b1;
          rx_reset_nxt = 1'b0;
          busy_nxt     = 1'b0;
        end else begin
          settle_cnt_nxt = settle_cnt + SETL_ONE;
        end
      end
    endcase
  end

  assign ctrl_bus.rx_clk_enable = clk_en;
  assign ctrl_bus.rx_mii_select = mii_sel;
  assign ctrl_bus.rx_rst        = rx_reset;
  assign ctrl_bus.speed         = cur_speed;
  assign ctrl_bus.switch_busy   = busy;

endmodule
